// File: rtl/riscv8_pkg.sv
// rtl/riscv8_pkg.sv - shared register-file constants and hazard cause encoding
package riscv8_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int OUT_W     = 4;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    // Highest-priority reason the current instruction is held, for debug/coverage.
    typedef enum logic [2:0] {
        HC_NONE,
        HC_RAW1,
        HC_RAW2,
        HC_WAW,
        HC_FULL
    } hazard_cause_t;

endpackage

// File: rtl/stall_watchdog.sv
// rtl/stall_watchdog.sv - saturating stall-run counter with sticky timeout flag
module stall_watchdog #(
    parameter int STALL_TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic stall,
    output logic hazard_timeout
);

    localparam logic [7:0] LIMIT = 8'(STALL_TIMEOUT);

    logic [7:0] run_cnt;

    // Count consecutive stall cycles; flag is raised on the edge the count reaches LIMIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cnt        <= '0;
            hazard_timeout <= 1'b0;
        end else if (flush) begin
            run_cnt        <= '0;
            hazard_timeout <= 1'b0;
        end else if (stall) begin
            if (run_cnt != LIMIT) begin
                run_cnt <= run_cnt + 8'd1;
            end
            if (run_cnt == LIMIT - 8'd1) begin
                hazard_timeout <= 1'b1;
            end
        end else begin
            run_cnt <= '0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit scoreboard gating issue on RAW/WAW/budget hazards
module regfile_scoreboard
    import riscv8_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_TIMEOUT   = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rs1,
    input  logic [REG_IDX_W-1:0] issue_rs2,
    input  logic                 issue_uses_rs2,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic                 issue_writes_rd,
    output logic                 stall,
    output logic                 issue_fire,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 flush,
    output logic [OUT_W-1:0]     outstanding,
    output logic [NUM_REGS-1:0]  busy_vec,
    output logic                 hazard_timeout
);

    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    logic          counted_wr;
    logic          raw1;
    logic          raw2;
    logic          waw;
    logic          full;
    logic          issue_set;
    logic          retire;
    logic [NUM_REGS-1:0] busy_next;
    hazard_cause_t cause;

    // Hazard terms are evaluated against registered state; writes to x0 are never tracked.
    always_comb begin
        counted_wr = issue_writes_rd & (issue_rd != REG_ZERO);
        raw1       = busy_vec[issue_rs1];
        raw2       = issue_uses_rs2 & busy_vec[issue_rs2];
        waw        = counted_wr & busy_vec[issue_rd];
        full       = counted_wr & (outstanding == OUT_MAX);
        stall      = issue_valid & (raw1 | raw2 | waw | full);
        issue_fire = issue_valid & ~stall;
        issue_set  = issue_fire & counted_wr;
        // A retire of a non-busy register is spurious and must not touch the count.
        retire     = wb_valid & (wb_rd != REG_ZERO) & busy_vec[wb_rd];
    end

    // Clear first, then set, so a same-register collision resolves to busy.
    always_comb begin
        busy_next = busy_vec;
        if (retire) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (issue_set) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    // Priority-encoded stall reason for observation only.
    always_comb begin
        cause = HC_NONE;
        if (issue_valid) begin
            if (raw1) begin
                cause = HC_RAW1;
            end else if (raw2) begin
                cause = HC_RAW2;
            end else if (waw) begin
                cause = HC_WAW;
            end else if (full) begin
                cause = HC_FULL;
            end
        end
    end

    // Busy bits and in-flight count; flush overrides any issue or retire this cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_vec    <= '0;
            outstanding <= '0;
        end else if (flush) begin
            busy_vec    <= '0;
            outstanding <= '0;
        end else begin
            busy_vec <= busy_next;
            case ({issue_set, retire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_stall_watchdog (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .stall          (stall),
        .hazard_timeout (hazard_timeout)
    );

    a_no_set_clear_collision: assert property (@(posedge clock) disable iff (reset)
        !(issue_set && retire && (issue_rd == wb_rd)));

    a_cause_matches_stall: assert property (@(posedge clock) disable iff (reset)
        ((cause != HC_NONE) == stall));

    a_budget_bounded: assert property (@(posedge clock) disable iff (reset)
        (outstanding <= OUT_MAX));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized and directed bench for regfile_scoreboard
module tb_regfile_scoreboard;

    localparam int MAXO = 4;
    localparam int TMO  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rs1 = '0;
    logic [4:0]  issue_rs2 = '0;
    logic        issue_uses_rs2 = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_writes_rd = 1'b0;
    logic        stall;
    logic        issue_fire;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic [3:0]  outstanding;
    logic [31:0] busy_vec;
    logic        hazard_timeout;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: which registers have a pending write, stall run length, sticky flag.
    bit mbusy [32];
    int mrun;
    bit mto;

    regfile_scoreboard #(
        .MAX_OUTSTANDING (MAXO),
        .STALL_TIMEOUT   (TMO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_rs1       (issue_rs1),
        .issue_rs2       (issue_rs2),
        .issue_uses_rs2  (issue_uses_rs2),
        .issue_rd        (issue_rd),
        .issue_writes_rd (issue_writes_rd),
        .stall           (stall),
        .issue_fire      (issue_fire),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .flush           (flush),
        .outstanding     (outstanding),
        .busy_vec        (busy_vec),
        .hazard_timeout  (hazard_timeout)
    );

    always #5 clock = ~clock;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += mbusy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = mbusy[i];
        return v;
    endfunction

    function automatic bit m_stall();
        bit pending_write;
        if (!issue_valid) return 1'b0;
        pending_write = issue_writes_rd && (issue_rd != 0);
        if (mbusy[issue_rs1]) return 1'b1;
        if (issue_uses_rs2 && mbusy[issue_rs2]) return 1'b1;
        if (pending_write && (mbusy[issue_rd] || m_count() == MAXO)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        mrun = 0;
        mto  = 1'b0;
    endfunction

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_uses_rs2 = 0;
        issue_rd = 0; issue_writes_rd = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic issue(input int rs1, input int rd, input bit wr);
        issue_valid = 1; issue_rs1 = 5'(rs1); issue_rs2 = 0; issue_uses_rs2 = 0;
        issue_rd = 5'(rd); issue_writes_rd = wr;
    endtask

    // One clock edge; the reference advances using the inputs held across that edge.
    task automatic step();
        bit s;
        s = m_stall();
        @(posedge clock);
        if (flush) begin
            m_clear();
        end else begin
            if (wb_valid && wb_rd != 0 && mbusy[wb_rd]) mbusy[wb_rd] = 1'b0;
            if (issue_valid && !s && issue_writes_rd && issue_rd != 0) mbusy[issue_rd] = 1'b1;
            if (s) begin
                if (mrun < TMO) mrun++;
                if (mrun == TMO) mto = 1'b1;
            end else begin
                mrun = 0;
            end
        end
        #1;
    endtask

    task automatic do_flush();
        idle(); flush = 1; step(); flush = 0;
    endtask

    task automatic test_reset();
        m_clear();
        #1;
        vectors++;
        if (busy_vec !== 32'h0 || outstanding !== 4'h0 || hazard_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%h out=%0d to=%0b expected 0/0/0", busy_vec, outstanding, hazard_timeout);
        end
        step();
        reset = 0;
        issue(0, 5, 1);
        step();
        idle();
        vectors++;
        if (busy_vec !== 32'h20 || outstanding !== 4'd1) begin
            miscompares++;
            $display("FAIL issue_rd5: busy=%h out=%0d expected 20/1", busy_vec, outstanding);
        end
        #3 reset = 1;
        #1;
        m_clear();
        vectors++;
        if (busy_vec !== 32'h0 || outstanding !== 4'h0 || hazard_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%h out=%0d to=%0b expected 0/0/0", busy_vec, outstanding, hazard_timeout);
        end
        #1 reset = 0;
    endtask

    task automatic test_raw_retire();
        do_flush();
        issue(0, 3, 1);
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++; $display("FAIL raw_first_issue: stall=%0b expected 0", stall);
        end
        step();
        issue(3, 0, 0);
        #1;
        vectors++;
        if (stall !== 1'b1 || issue_fire !== 1'b0) begin
            miscompares++; $display("FAIL raw_stall: stall=%0b fire=%0b expected 1/0", stall, issue_fire);
        end
        step();
        wb_valid = 1; wb_rd = 3;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++; $display("FAIL raw_wb_cycle: stall=%0b expected 1", stall);
        end
        step();
        wb_valid = 0;
        #1;
        vectors++;
        if (stall !== 1'b0 || busy_vec[3] !== 1'b0 || issue_fire !== 1'b1) begin
            miscompares++;
            $display("FAIL raw_after_wb: stall=%0b busy3=%0b fire=%0b expected 0/0/1", stall, busy_vec[3], issue_fire);
        end
        step();
        idle();
    endtask

    task automatic test_budget();
        do_flush();
        for (int r = 1; r <= 4; r++) begin
            issue(0, r, 1);
            step();
        end
        issue(0, 6, 1);
        #1;
        vectors++;
        if (outstanding !== 4'd4 || stall !== 1'b1) begin
            miscompares++; $display("FAIL budget_full: out=%0d stall=%0b expected 4/1", outstanding, stall);
        end
        step();
        wb_valid = 1; wb_rd = 1;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++; $display("FAIL budget_wb_cycle: stall=%0b expected 1", stall);
        end
        step();
        wb_valid = 0;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++; $display("FAIL budget_release: stall=%0b expected 0", stall);
        end
        step();
        idle();
        vectors++;
        if (outstanding !== 4'd4 || busy_vec !== 32'h5C) begin
            miscompares++; $display("FAIL budget_refill: out=%0d busy=%h expected 4/5c", outstanding, busy_vec);
        end
    endtask

    task automatic test_x0_spurious();
        do_flush();
        issue(0, 0, 1);
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++; $display("FAIL x0_stall: stall=%0b expected 0", stall);
        end
        step();
        vectors++;
        if (outstanding !== 4'd0 || busy_vec !== 32'h0) begin
            miscompares++; $display("FAIL x0_count: out=%0d busy=%h expected 0/0", outstanding, busy_vec);
        end
        idle(); wb_valid = 1; wb_rd = 7;
        step();
        vectors++;
        if (outstanding !== 4'd0) begin
            miscompares++; $display("FAIL spurious_wb_empty: out=%0d expected 0", outstanding);
        end
        issue(0, 5, 1); wb_valid = 0;
        step();
        idle(); wb_valid = 1; wb_rd = 7;
        step();
        idle();
        vectors++;
        if (outstanding !== 4'd1 || busy_vec !== 32'h20) begin
            miscompares++; $display("FAIL spurious_wb_busy: out=%0d busy=%h expected 1/20", outstanding, busy_vec);
        end
    endtask

    task automatic test_waw_simul();
        do_flush();
        issue(0, 9, 1);
        step();
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++; $display("FAIL waw_stall: stall=%0b expected 1", stall);
        end
        step();
        issue(0, 10, 1); wb_valid = 1; wb_rd = 9;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++; $display("FAIL simul_stall: stall=%0b expected 0", stall);
        end
        step();
        idle();
        vectors++;
        if (busy_vec[10] !== 1'b1 || busy_vec[9] !== 1'b0 || outstanding !== 4'd1) begin
            miscompares++;
            $display("FAIL simul_update: b10=%0b b9=%0b out=%0d expected 1/0/1", busy_vec[10], busy_vec[9], outstanding);
        end
    endtask

    task automatic test_watchdog_flush();
        do_flush();
        issue(0, 12, 1);
        step();
        issue(12, 0, 0);
        for (int c = 1; c <= 7; c++) step();
        vectors++;
        if (hazard_timeout !== 1'b0) begin
            miscompares++; $display("FAIL wd_early: to=%0b expected 0 after 7 stalls", hazard_timeout);
        end
        step();
        vectors++;
        if (hazard_timeout !== 1'b1) begin
            miscompares++; $display("FAIL wd_set: to=%0b expected 1 after 8 stalls", hazard_timeout);
        end
        for (int c = 0; c < 3; c++) step();
        vectors++;
        if (hazard_timeout !== 1'b1) begin
            miscompares++; $display("FAIL wd_sticky: to=%0b expected 1", hazard_timeout);
        end
        flush = 1;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++; $display("FAIL flush_pre_state: stall=%0b expected 1", stall);
        end
        step();
        flush = 0;
        #1;
        vectors++;
        if (busy_vec !== 32'h0 || outstanding !== 4'd0 || hazard_timeout !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear: busy=%h out=%0d to=%0b stall=%0b expected 0/0/0/0",
                     busy_vec, outstanding, hazard_timeout, stall);
        end
        idle();
        step();
    endtask

    task automatic test_random();
        int start;
        bit found;
        do_flush();
        for (int i = 0; i < 500; i++) begin
            issue_valid     = ($urandom_range(0, 9) < 7);
            issue_rs1       = 5'($urandom_range(0, 7));
            issue_rs2       = 5'($urandom_range(0, 7));
            issue_uses_rs2  = 1'($urandom_range(0, 1));
            issue_rd        = 5'($urandom_range(0, 7));
            issue_writes_rd = ($urandom_range(0, 3) != 0);
            wb_valid        = 1'($urandom_range(0, 1));
            wb_rd           = 5'($urandom_range(0, 7));
            found = 0;
            if (wb_valid && $urandom_range(0, 3) != 0) begin
                start = $urandom_range(0, 31);
                for (int j = 0; j < 32; j++) begin
                    if (!found && mbusy[(start + j) % 32]) begin
                        wb_rd = 5'((start + j) % 32);
                        found = 1;
                    end
                end
            end
            flush = ($urandom_range(0, 63) == 0);
            #1;
            vectors++;
            if (stall !== m_stall() || issue_fire !== (issue_valid && !m_stall())) begin
                miscompares++;
                $display("FAIL rnd_stall[%0d]: stall=%0b fire=%0b expected %0b/%0b",
                         i, stall, issue_fire, m_stall(), issue_valid && !m_stall());
            end
            step();
            vectors++;
            if (busy_vec !== m_vec() || outstanding !== 4'(m_count()) || hazard_timeout !== mto) begin
                miscompares++;
                $display("FAIL rnd_state[%0d]: busy=%h out=%0d to=%0b expected %h/%0d/%0b",
                         i, busy_vec, outstanding, hazard_timeout, m_vec(), m_count(), mto);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_raw_retire();
        test_budget();
        test_x0_spurious();
        test_waw_simul();
        test_watchdog_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Hazard controller that sequences access to the 32 x 8-bit register file for the in-order pipeline. It tracks one busy bit per architectural register for writes that have been issued but not yet retired. It holds issue (stall) on RAW and WAW hazards and when the outstanding-write budget is exhausted. It also raises a sticky watchdog flag if a stall persists too long.

Parameters:
NUM_REGS, 32, number of architectural registers (index width = clog2)
MAX_OUTSTANDING, 4, maximum in-flight register writes (1..15)
STALL_TIMEOUT, 255, consecutive stall cycles before hazard_timeout sets (1..255)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
issue_valid  input  1  decode stage presents an instruction
issue_rs1  input  5  source register 1
issue_rs2  input  5  source register 2
issue_uses_rs2  input  1  instruction reads rs2
issue_rd  input  5  destination register
issue_writes_rd  input  1  instruction writes rd
stall  output  1  combinational; 1 = hold decode, instruction not accepted
issue_fire  output  1  combinational; issue_valid & ~stall
wb_valid  input  1  write-back stage writes the register file this cycle (mirrors reg_write)
wb_rd  input  5  write-back destination
flush  input  1  synchronous; clears all busy bits and the outstanding count
outstanding  output  4  registered count of in-flight writes
busy_vec  output  32  registered busy bits, bit i = register i pending
hazard_timeout  output  1  registered, sticky until reset or flush

Behaviour:
- Reset (async): busy_vec=0, outstanding=0, stall-run counter=0, hazard_timeout=0.
- Register 0 never becomes busy. Writes with issue_rd=0 do not count as outstanding.
- Retire window: the register file captures read data on the same edge it writes. A read of wb_rd in the wb cycle therefore returns stale data. Sources still stall during the wb cycle, so busy is cleared at the end of the wb cycle.
- stall = issue_valid & (raw1 | raw2 | waw | full).
  - raw1 = busy[rs1].
  - raw2 = issue_uses_rs2 & busy[rs2].
  - waw = issue_writes_rd & rd!=0 & busy[rd].
  - full = issue_writes_rd & rd!=0 & outstanding==MAX_OUTSTANDING.
- stall is 0 when issue_valid=0.
- Same-edge update:
  - On issue_fire with a counted write: busy[rd] is set.
  - On wb_valid & wb_rd!=0 & busy[wb_rd]: busy[wb_rd] is cleared.
  - If both target the same register, set wins. This is unreachable given the WAW rule; an assertion covers it.
- outstanding: +1 on a counted issue, -1 on a valid retire, unchanged if both occur.
  - A wb to a non-busy register is ignored (no decrement, no underflow).
  - outstanding never exceeds MAX_OUTSTANDING.
- flush (synchronous, priority over issue/wb in that cycle):
  - busy_vec=0, outstanding=0, run counter=0, hazard_timeout=0.
  - stall remains combinational from pre-flush state.
- Watchdog:
  - The run counter increments each cycle stall=1 and saturates at STALL_TIMEOUT.
  - It clears when stall=0.
  - hazard_timeout sets on the edge where the counter reaches STALL_TIMEOUT and stays set.
- No internal FSM beyond counters. The latency from wb to an unstalled dependent issue is 1 cycle after the wb cycle.

Decomposition:
- Shared package (riscv8_pkg): REG_IDX_W=5, NUM_REGS, REG_ZERO constant, and a hazard_cause enum {NONE, RAW1, RAW2, WAW, FULL} for debug/coverage.
- One natural sub-module: stall_watchdog (saturating run counter plus sticky flag). Everything else stays in regfile_scoreboard.

Test Plan:
1. Reset mid-operation: issue rd=5 (busy_vec[5]=1), then assert reset asynchronously between edges -> busy_vec=0, outstanding=0, hazard_timeout=0 immediately.
2. RAW stall and retire window: issue rd=3. Next cycle issue rs1=3 -> stall=1. wb_valid, wb_rd=3 in cycle N -> stall=1 in cycle N, stall=0 in cycle N+1, busy_vec[3]=0.
3. Budget limit, MAX_OUTSTANDING=4: issue rd=1,2,3,4 -> outstanding=4. Issue rd=6 -> stall=1. wb rd=1 -> rd=6 issues the following cycle, outstanding returns to 4.
4. x0 and spurious wb: issue rd=0 -> no stall, outstanding=0. wb_rd=7 with busy[7]=0 -> outstanding unchanged, no underflow.
5. WAW and simultaneous events: rd=9 busy, issue rd=9 -> stall. In one cycle issue rd=10 while wb rd=9 -> busy_vec[10]=1, busy_vec[9]=0, outstanding unchanged.
6. Watchdog and flush, STALL_TIMEOUT=8: hold a RAW stall 8 cycles -> hazard_timeout=1 on the 8th edge and stays set. Assert flush -> all state cleared and stall=0 the next cycle.
